// File: rtl/i2c_slave_reader.sv
// i2c_slave_reader: I2C target that answers read transactions only.
// It matches a 7-bit address with the R/W bit set, ACKs it, then shifts out
// tx_data MSB-first as NUM_BYTES bytes (tx_data[15:8] first) and follows the
// master's ACK/NACK. SCL is input-only and there is no clock stretching.
//
// Ports:
//   clk        system clock; an SCL half-period must last at least 8 clk cycles
//   reset      asynchronous active-high reset
//   scl        I2C clock (input only)
//   sda        I2C data, open-drain: pulled to 0 when sda_oe_q=1, else 'z'
//   tx_data    word to return, captured when the address matches
//   data_req   one-clk pulse when tx_data is captured
//   busy       high from address match until STOP, repeated START or reset
//   xfer_done  one-clk pulse once the master's ACK bit after the final byte is sampled
//   nack_seen  one-clk pulse when the master NACKs a byte before the last one
`timescale 1ns/1ps
module i2c_slave_reader #(
    parameter logic [6:0]  SLAVE_ADDR = 7'b0101101,
    parameter int unsigned NUM_BYTES  = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        scl,
    inout  wire         sda,
    input  logic [15:0] tx_data,
    output logic        data_req,
    output logic        busy,
    output logic        xfer_done,
    output logic        nack_seen
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_ADDR_ACK,
        S_TX_BYTE,
        S_MACK,
        S_WAIT_STOP
    } state_t;

    // Index of the final byte: 0 when only one byte is returned.
    localparam logic LAST_BYTE = (NUM_BYTES > 1) ? 1'b1 : 1'b0;

    // Synchronizers plus one extra stage for edge detection. They reset to
    // the idle-bus level so that leaving reset is not mistaken for bus activity.
    logic scl_s1_q, scl_s2_q, scl_prev_q;
    logic sda_s1_q, sda_s2_q, sda_prev_q;

    state_t      state_q, state_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic        byte_cnt_q, byte_cnt_d;
    logic [7:0]  addr_sr_q, addr_sr_d;
    logic [15:0] data_q, data_d;
    logic        sda_oe_q, sda_oe_d;
    logic        busy_q, busy_d;
    logic        data_req_q, data_req_d;
    logic        xfer_done_q, xfer_done_d;
    logic        nack_seen_q, nack_seen_d;
    logic [2:0]  oe_chg_q, oe_chg_d;

    logic       scl_rise, scl_fall, start_det, stop_det, own_edge;
    logic [7:0] cur_byte;
    logic [2:0] bit_idx;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scl_s1_q   <= 1'b1;
            scl_s2_q   <= 1'b1;
            scl_prev_q <= 1'b1;
            sda_s1_q   <= 1'b1;
            sda_s2_q   <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_s1_q   <= scl;
            scl_s2_q   <= scl_s1_q;
            scl_prev_q <= scl_s2_q;
            sda_s1_q   <= sda;
            sda_s2_q   <= sda_s1_q;
            sda_prev_q <= sda_s2_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            bit_cnt_q   <= '0;
            byte_cnt_q  <= 1'b0;
            addr_sr_q   <= '0;
            data_q      <= '0;
            sda_oe_q    <= 1'b0;
            busy_q      <= 1'b0;
            data_req_q  <= 1'b0;
            xfer_done_q <= 1'b0;
            nack_seen_q <= 1'b0;
            oe_chg_q    <= '0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            byte_cnt_q  <= byte_cnt_d;
            addr_sr_q   <= addr_sr_d;
            data_q      <= data_d;
            sda_oe_q    <= sda_oe_d;
            busy_q      <= busy_d;
            data_req_q  <= data_req_d;
            xfer_done_q <= xfer_done_d;
            nack_seen_q <= nack_seen_d;
            oe_chg_q    <= oe_chg_d;
        end
    end

    always_comb begin
        scl_rise = scl_s2_q & ~scl_prev_q;
        scl_fall = ~scl_s2_q & scl_prev_q;
        // An sda_oe change reaches the synchronized SDA two clocks later; the
        // three-deep history masks that window so our own edges never look
        // like START or STOP.
        own_edge  = |oe_chg_q;
        start_det = scl_s2_q & scl_prev_q & sda_prev_q & ~sda_s2_q & ~own_edge;
        stop_det  = scl_s2_q & scl_prev_q & ~sda_prev_q & sda_s2_q & ~own_edge;
        cur_byte  = (byte_cnt_q & LAST_BYTE) ? data_q[7:0] : data_q[15:8];
        bit_idx   = 3'd7 - bit_cnt_q[2:0];
    end

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        byte_cnt_d  = byte_cnt_q;
        addr_sr_d   = addr_sr_q;
        data_d      = data_q;
        sda_oe_d    = sda_oe_q;
        busy_d      = busy_q;
        data_req_d  = 1'b0;
        xfer_done_d = 1'b0;
        nack_seen_d = 1'b0;

        if (stop_det) begin
            state_d    = S_IDLE;
            sda_oe_d   = 1'b0;
            busy_d     = 1'b0;
            bit_cnt_d  = '0;
            byte_cnt_d = 1'b0;
        end else if (start_det) begin
            // Plain START from IDLE and repeated START share one path.
            state_d    = S_ADDR;
            sda_oe_d   = 1'b0;
            busy_d     = 1'b0;
            bit_cnt_d  = '0;
            byte_cnt_d = 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    sda_oe_d = 1'b0;
                end
                S_ADDR: begin
                    if (scl_rise && bit_cnt_q < 4'd8) begin
                        addr_sr_d = {addr_sr_q[6:0], sda_s2_q};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall && bit_cnt_q == 4'd8) begin
                        if (addr_sr_q[7:1] == SLAVE_ADDR && addr_sr_q[0]) begin
                            sda_oe_d   = 1'b1;
                            data_d     = tx_data;
                            data_req_d = 1'b1;
                            busy_d     = 1'b1;
                            state_d    = S_ADDR_ACK;
                        end else begin
                            sda_oe_d = 1'b0;
                            state_d  = S_WAIT_STOP;
                        end
                    end
                end
                S_ADDR_ACK: begin
                    if (scl_fall) begin
                        sda_oe_d   = ~data_q[15];
                        byte_cnt_d = 1'b0;
                        bit_cnt_d  = '0;
                        state_d    = S_TX_BYTE;
                    end
                end
                S_TX_BYTE: begin
                    if (scl_rise && bit_cnt_q < 4'd8) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall && bit_cnt_q == 4'd8) begin
                        sda_oe_d = 1'b0;
                        state_d  = S_MACK;
                    end else if (scl_fall && bit_cnt_q != 4'd0) begin
                        sda_oe_d = ~cur_byte[bit_idx];
                    end
                end
                S_MACK: begin
                    // bit_cnt 8: waiting for the master's ACK bit;
                    // bit_cnt 9: ACK seen, next byte starts on the coming fall.
                    if (scl_rise && bit_cnt_q == 4'd8) begin
                        if (byte_cnt_q != LAST_BYTE) begin
                            if (!sda_s2_q) begin
                                bit_cnt_d = 4'd9;
                            end else begin
                                nack_seen_d = 1'b1;
                                state_d     = S_WAIT_STOP;
                            end
                        end else begin
                            xfer_done_d = 1'b1;
                            state_d     = S_WAIT_STOP;
                        end
                    end else if (scl_fall && bit_cnt_q == 4'd9) begin
                        sda_oe_d   = ~data_q[7];
                        byte_cnt_d = 1'b1;
                        bit_cnt_d  = '0;
                        state_d    = S_TX_BYTE;
                    end
                end
                S_WAIT_STOP: begin
                    sda_oe_d = 1'b0;
                end
                default: begin
                    state_d  = S_IDLE;
                    sda_oe_d = 1'b0;
                end
            endcase
        end

        oe_chg_d = {oe_chg_q[1:0], sda_oe_d != sda_oe_q};
    end

    assign sda       = sda_oe_q ? 1'b0 : 1'bz;
    assign data_req  = data_req_q;
    assign busy      = busy_q;
    assign xfer_done = xfer_done_q;
    assign nack_seen = nack_seen_q;

endmodule

// File: tb/tb_i2c_slave_reader.sv
`timescale 1ns/1ps
module tb_i2c_slave_reader;

    localparam time Q = 50ns;  // quarter of an SCL bit period (5 clk)

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        scl = 1'b1;
    logic        m_sda_low = 1'b0;
    logic [15:0] tx_data = 16'h0000;
    logic        data_req, busy, xfer_done, nack_seen;
    wire         sda_bus;

    pullup (sda_bus);
    assign sda_bus = m_sda_low ? 1'b0 : 1'bz;

    int n_checks = 0;
    int n_errors = 0;
    int n_req = 0, n_done = 0, n_nack = 0, n_slave_low = 0;

    always #5 clk = ~clk;

    i2c_slave_reader #(.SLAVE_ADDR(7'b0101101), .NUM_BYTES(2)) dut (
        .clk      (clk),
        .reset    (reset),
        .scl      (scl),
        .sda      (sda_bus),
        .tx_data  (tx_data),
        .data_req (data_req),
        .busy     (busy),
        .xfer_done(xfer_done),
        .nack_seen(nack_seen)
    );

    always @(negedge clk) begin
        if (data_req)  n_req++;
        if (xfer_done) n_done++;
        if (nack_seen) n_nack++;
        if (!m_sda_low && sda_bus == 1'b0) n_slave_low++;
    end

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Works from an idle bus and as a repeated START with SCL low.
    task automatic i2c_start();
        #Q m_sda_low = 1'b0;
        #Q scl = 1'b1;
        #Q m_sda_low = 1'b1;
        #Q scl = 1'b0;
    endtask

    task automatic i2c_stop();
        #Q m_sda_low = 1'b1;
        #Q scl = 1'b1;
        #Q m_sda_low = 1'b0;
        #Q;
    endtask

    task automatic write_bit(input logic b);
        #Q m_sda_low = ~b;
        #Q scl = 1'b1;
        #Q;
        #Q scl = 1'b0;
    endtask

    task automatic read_bit(output logic b);
        #Q m_sda_low = 1'b0;
        #Q scl = 1'b1;
        #Q b = sda_bus;
        #Q scl = 1'b0;
    endtask

    task automatic write_byte(input logic [7:0] v, output logic ack);
        for (int i = 7; i >= 0; i--) write_bit(v[i]);
        read_bit(ack);
    endtask

    task automatic read_byte(output logic [7:0] v, input logic mack);
        logic b;
        v = '0;
        for (int i = 0; i < 8; i++) begin
            read_bit(b);
            v = {v[6:0], b};
        end
        write_bit(~mack);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish within 1 ms");
        $fatal(1);
    end

    initial begin
        logic       ack, b;
        logic [7:0] v;
        logic [2:0] part;
        int r0, d0, k0, s0;

        // Reset state
        #20;
        check("rst_busy", 16'(busy), 16'd0);
        check("rst_req", 16'(data_req), 16'd0);
        check("rst_done", 16'(xfer_done), 16'd0);
        check("rst_nack", 16'(nack_seen), 16'd0);
        check("rst_sda", 16'(sda_bus), 16'd1);
        #13 reset = 1'b0;
        #100;

        // Full read: ACK byte0, NACK byte1; tx_data changed after capture
        r0 = n_req; d0 = n_done; k0 = n_nack;
        tx_data = 16'hA55A;
        i2c_start();
        write_byte(8'h5B, ack);
        check("rd_addr_ack", 16'(ack), 16'd0);
        check("rd_busy", 16'(busy), 16'd1);
        tx_data = 16'h0000;
        read_byte(v, 1'b1);
        check("rd_byte0", 16'(v), 16'h00A5);
        read_byte(v, 1'b0);
        check("rd_byte1", 16'(v), 16'h005A);
        check("rd_busy_before_stop", 16'(busy), 16'd1);
        i2c_stop();
        #Q;
        check("rd_busy_after_stop", 16'(busy), 16'd0);
        check("rd_req_cnt", 16'(n_req - r0), 16'd1);
        check("rd_done_cnt", 16'(n_done - d0), 16'd1);
        check("rd_nack_cnt", 16'(n_nack - k0), 16'd0);

        // Wrong address (0x2C read): bus never pulled by the target
        r0 = n_req; d0 = n_done; k0 = n_nack; s0 = n_slave_low;
        tx_data = 16'hFFFF;
        i2c_start();
        write_byte(8'h59, ack);
        check("wa_ack", 16'(ack), 16'd1);
        check("wa_busy", 16'(busy), 16'd0);
        read_byte(v, 1'b0);
        check("wa_byte", 16'(v), 16'h00FF);
        i2c_stop();
        check("wa_slave_low", 16'(n_slave_low - s0), 16'd0);
        check("wa_pulses", 16'((n_req - r0) + (n_done - d0) + (n_nack - k0)), 16'd0);

        // Matching address with write bit: not acknowledged
        r0 = n_req;
        i2c_start();
        write_byte(8'h5A, ack);
        check("wr_ack", 16'(ack), 16'd1);
        check("wr_busy", 16'(busy), 16'd0);
        i2c_stop();
        check("wr_req_cnt", 16'(n_req - r0), 16'd0);

        // Master NACKs byte0
        d0 = n_done; k0 = n_nack;
        tx_data = 16'hA55A;
        i2c_start();
        write_byte(8'h5B, ack);
        check("nk_addr_ack", 16'(ack), 16'd0);
        read_byte(v, 1'b0);
        check("nk_byte0", 16'(v), 16'h00A5);
        check("nk_nack_cnt", 16'(n_nack - k0), 16'd1);
        s0 = n_slave_low;
        read_byte(v, 1'b0);
        check("nk_byte1_released", 16'(v), 16'h00FF);
        check("nk_slave_low", 16'(n_slave_low - s0), 16'd0);
        i2c_stop();
        check("nk_done_cnt", 16'(n_done - d0), 16'd0);
        check("nk_busy", 16'(busy), 16'd0);

        // STOP after 3 bits of byte0, then a fresh read
        d0 = n_done; k0 = n_nack;
        tx_data = 16'hB00F;
        i2c_start();
        write_byte(8'h5B, ack);
        check("sp_addr_ack", 16'(ack), 16'd0);
        part = '0;
        for (int i = 0; i < 3; i++) begin
            read_bit(b);
            part = {part[1:0], b};
        end
        check("sp_3bits", 16'(part), 16'h0005);
        i2c_stop();
        #Q;
        check("sp_busy", 16'(busy), 16'd0);
        check("sp_sda", 16'(sda_bus), 16'd1);
        check("sp_no_pulses", 16'((n_done - d0) + (n_nack - k0)), 16'd0);
        d0 = n_done;
        tx_data = 16'h3CC3;
        i2c_start();
        write_byte(8'h5B, ack);
        check("sp2_addr_ack", 16'(ack), 16'd0);
        read_byte(v, 1'b1);
        check("sp2_byte0", 16'(v), 16'h003C);
        read_byte(v, 1'b0);
        check("sp2_byte1", 16'(v), 16'h00C3);
        i2c_stop();
        check("sp2_done_cnt", 16'(n_done - d0), 16'd1);

        // Repeated START after byte0's ACK, then a new read
        r0 = n_req; d0 = n_done;
        tx_data = 16'hA5C3;
        i2c_start();
        write_byte(8'h5B, ack);
        read_byte(v, 1'b1);
        check("rs_byte0", 16'(v), 16'h00A5);
        i2c_start();
        check("rs_busy_cleared", 16'(busy), 16'd0);
        tx_data = 16'h1234;
        write_byte(8'h5B, ack);
        check("rs_addr_ack", 16'(ack), 16'd0);
        read_byte(v, 1'b1);
        check("rs_byte0_new", 16'(v), 16'h0012);
        read_byte(v, 1'b0);
        check("rs_byte1_new", 16'(v), 16'h0034);
        i2c_stop();
        check("rs_req_cnt", 16'(n_req - r0), 16'd2);
        check("rs_done_cnt", 16'(n_done - d0), 16'd1);

        // Reset pulse while the target drives a 0 bit
        d0 = n_done; k0 = n_nack;
        tx_data = 16'h1234;
        i2c_start();
        write_byte(8'h5B, ack);
        #Q;
        check("rr_driving", 16'(sda_bus), 16'd0);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("rr_sda_released", 16'(sda_bus), 16'd1);
        check("rr_busy", 16'(busy), 16'd0);
        check("rr_outs", 16'({data_req, xfer_done, nack_seen}), 16'd0);
        #20 reset = 1'b0;
        read_byte(v, 1'b0);
        check("rr_ignored", 16'(v), 16'h00FF);
        i2c_stop();
        check("rr_no_pulses", 16'((n_done - d0) + (n_nack - k0)), 16'd0);
        tx_data = 16'hBEEF;
        i2c_start();
        write_byte(8'h5B, ack);
        check("rr2_addr_ack", 16'(ack), 16'd0);
        read_byte(v, 1'b1);
        check("rr2_byte0", 16'(v), 16'h00BE);
        read_byte(v, 1'b0);
        check("rr2_byte1", 16'(v), 16'h00EF);
        i2c_stop();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
